iterative_alu: RTL
==================

// Module: iterative_alu
// PURPOSE
//   Parametrised multi-cycle successor to the single-cycle datapath ALU. Executes the
//   existing op set (add, sub, and, xor, sra, slt) in one cycle. Adds iterative unsigned
//   multiply (shift-add) and unsigned divide (restoring), one bit per cycle.
//   Sits in the execute stage of the multi-cycle core. Uses a start/busy/done handshake
//   so the control FSM stalls on long ops.
// PARAMETERS
//   WIDTH  32  operand/result width; power of two, >= 4; shift amount = B[$clog2(WIDTH)-1:0]
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-high
//   start         in   1      request; accepted only on an edge where busy==0
//   ALUControl    in   3      000 add, 001 sub, 010 and, 011 xor, 100 sra, 101 slt, 110 mulu, 111 divu
//   A, B          in   WIDTH  operands; sampled only on the accepting edge
//   result        out  WIDTH  sum/diff/logic/shift/slt; low product; quotient
//   result_hi     out  WIDTH  high product (mulu); remainder (divu); 0 for all other ops
//   zero          out  1      registered (result == 0), updated together with result
//   cout          out  1      carry out of add/sub (sub: 1 = no borrow); 0 for other ops
//   div_by_zero   out  1      1 when the completed divu had B == 0; else 0
//   busy          out  1      1 while a mulu/divu is iterating
//   done          out  1      one-cycle pulse: result/flags valid and stable from here
// BEHAVIOUR
//   Reset, sync and dominant over start: state=IDLE, all outputs 0, iteration counter 0.
//   Reset mid-operation aborts the op; no done pulse is issued for it.
//   FSM states: IDLE, RUN.
//   IDLE & start, op 000..101: op computed from A/B at the accepting edge E0. result,
//     result_hi=0, zero, cout and done=1 are registered at E0. State stays IDLE.
//   IDLE & start, op 110/111: A/B/op are latched at E0. busy=1, counter=WIDTH, state=RUN.
//     No done at E0.
//   divu with B==0 short-circuits as a 1-cycle op: result={WIDTH{1}}, result_hi=A,
//     div_by_zero=1, done at E0.
//   RUN: one iteration per edge E1..E_WIDTH.
//     mulu: 2*WIDTH-bit shift-add.
//     divu: restoring; remainder register WIDTH+1 bits.
//   At E_WIDTH: {result_hi,result} are written, zero/done=1, busy=0, state=IDLE.
//     Latency is WIDTH edges after E0.
//   Arithmetic:
//     sub = A + ~B + 1.
//     slt is signed: result = {WIDTH-1 zeros, (A<B)}.
//     sra is arithmetic: A >>> B[$clog2(WIDTH)-1:0].
//     Overflow wraps modulo 2^WIDTH.
//   done is high for exactly one cycle per completed op and is deasserted the following cycle.
//   result/result_hi/flags hold until the next completion or reset.
//   start while busy==1 is ignored: no queueing, no effect on the running op.
//     A/B/ALUControl changes during RUN have no effect.
//   Back-to-back: start is accepted in the same cycle done is high.
//     For 1-cycle ops, one result per cycle is sustained.
//   zero and cout reflect the last completed op only.
//   div_by_zero is cleared on the next completed op.
// TESTING (WIDTH=32)
//   1. add 0x7FFFFFFF+0x00000001 -> result 0x80000000, cout 0, zero 0, done 1 cycle after
//      start. sub 5-5 -> result 0, zero 1, cout 1.
//   2. sra A=0x80000000,B=4 -> 0xF8000000. slt A=0xFFFFFFFB(-5),B=3 -> 1.
//      and 0xF0F0F0F0&0x0FF00FF0 -> 0x00F000F0. xor A^A -> 0, zero 1.
//   3. mulu 0xFFFFFFFF*2 -> result 0xFFFFFFFE, result_hi 0x00000001.
//      busy high for exactly 32 cycles; done exactly 32 edges after accepting edge.
//   4. divu 100/7 -> result 14, result_hi 2, div_by_zero 0, latency 32 edges.
//      divu 9/0 -> result 0xFFFFFFFF, result_hi 9, div_by_zero 1, done after 1 edge.
//   5. During a mulu, pulse start with divu and change A/B at cycle 5 -> ignored.
//      The original product is returned, and exactly one done pulse is issued.
//   6. Assert reset at edge E10 of a mulu -> next cycle busy 0, done 0, all outputs 0,
//      no later done. An add start in the following cycle completes normally.
//      Also: reset and start in the same cycle -> reset wins.

Source files
------------

// File: rtl/iterative_alu_if.sv
// Purpose: bus bundle for iterative_alu (request, operands, results, handshake).
// Signals:
//   start, ALUControl, A, B              requester -> ALU
//   result, result_hi, zero, cout,       ALU -> requester
//   div_by_zero, busy, done
// Modports: master (requester side), slave (ALU side).
interface iterative_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             cout;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUControl, A, B,
        input  result, result_hi, zero, cout, div_by_zero, busy, done
    );

    modport slave (
        input  start, ALUControl, A, B,
        output result, result_hi, zero, cout, div_by_zero, busy, done
    );
endinterface

// File: rtl/iterative_alu.sv
// Purpose: execute-stage ALU. add/sub/and/xor/sra/slt complete on the accepting
//   edge; mulu (shift-add) and divu (restoring) iterate one bit per cycle and
//   complete WIDTH edges after acceptance. start/busy/done handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any running op
//   bus    iterative_alu_if.slave: start, ALUControl, A, B in;
//          result, result_hi, zero, cout, div_by_zero, busy, done out (all registered)
module iterative_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    iterative_alu_if.slave   bus
);
    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CNTW = SHW + 1;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(WIDTH);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_DIVU = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic [WIDTH-1:0] r_opnd, w_opnd_nxt;   // multiplicand or divisor
    logic [WIDTH-1:0] r_acc, w_acc_nxt;     // product high half or partial remainder
    logic [WIDTH-1:0] r_lo, w_lo_nxt;       // multiplier->product low, or dividend->quotient
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [WIDTH-1:0] r_result_hi, w_result_hi_nxt;
    logic             r_zero, w_zero_nxt;
    logic             r_cout, w_cout_nxt;
    logic             r_dbz, w_dbz_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    // Single-cycle datapath
    logic [WIDTH:0]   w_add, w_sub;
    logic [WIDTH-1:0] w_fast_res;
    logic             w_fast_cout;

    assign w_add = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_sub = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);

    always_comb begin
        w_fast_res  = '0;
        w_fast_cout = 1'b0;
        case (bus.ALUControl)
            OP_ADD: begin w_fast_res = w_add[WIDTH-1:0]; w_fast_cout = w_add[WIDTH]; end
            OP_SUB: begin w_fast_res = w_sub[WIDTH-1:0]; w_fast_cout = w_sub[WIDTH]; end
            OP_AND: w_fast_res = bus.A & bus.B;
            OP_XOR: w_fast_res = bus.A ^ bus.B;
            OP_SRA: w_fast_res = WIDTH'($signed(bus.A) >>> bus.B[SHW-1:0]);
            OP_SLT: w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            default: w_fast_res = '0;
        endcase
    end

    // One iteration step; mul shifts right into the low half, div shifts left out of it
    logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_trial;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_acc_step, w_lo_step;

    assign w_mul_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : (WIDTH+1)'(0));
    assign w_div_shift = {r_acc, r_lo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};
    assign w_div_ok    = ~w_div_trial[WIDTH];

    always_comb begin
        if (r_is_div) begin
            // a failed trial means the shifted remainder is below the divisor, so its MSB is 0
            w_acc_step = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            w_lo_step  = {r_lo[WIDTH-2:0], w_div_ok};
        end else begin
            w_acc_step = w_mul_sum[WIDTH:1];
            w_lo_step  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_div_nxt    = r_is_div;
        w_opnd_nxt      = r_opnd;
        w_acc_nxt       = r_acc;
        w_lo_nxt        = r_lo;
        w_result_nxt    = r_result;
        w_result_hi_nxt = r_result_hi;
        w_zero_nxt      = r_zero;
        w_cout_nxt      = r_cout;
        w_dbz_nxt       = r_dbz;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.ALUControl[2:1] == 2'b11) begin
                        if (bus.ALUControl == OP_DIVU && bus.B == '0) begin
                            w_result_nxt    = '1;
                            w_result_hi_nxt = bus.A;
                            w_zero_nxt      = 1'b0;
                            w_cout_nxt      = 1'b0;
                            w_dbz_nxt       = 1'b1;
                            w_done_nxt      = 1'b1;
                        end else begin
                            w_state_nxt  = RUN;
                            w_busy_nxt   = 1'b1;
                            w_cnt_nxt    = CNT_INIT;
                            w_is_div_nxt = bus.ALUControl[0];
                            w_opnd_nxt   = bus.B;
                            w_acc_nxt    = '0;
                            w_lo_nxt     = bus.A;
                        end
                    end else begin
                        w_result_nxt    = w_fast_res;
                        w_result_hi_nxt = '0;
                        w_zero_nxt      = (w_fast_res == '0);
                        w_cout_nxt      = w_fast_cout;
                        w_dbz_nxt       = 1'b0;
                        w_done_nxt      = 1'b1;
                    end
                end
            end
            RUN: begin
                w_acc_nxt = w_acc_step;
                w_lo_nxt  = w_lo_step;
                w_cnt_nxt = r_cnt - CNTW'(1);
                if (r_cnt == CNTW'(1)) begin
                    // both ops leave {high, low} as {acc, lo}
                    w_state_nxt     = IDLE;
                    w_busy_nxt      = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_result_nxt    = w_lo_step;
                    w_result_hi_nxt = w_acc_step;
                    w_zero_nxt      = (w_lo_step == '0);
                    w_cout_nxt      = 1'b0;
                    w_dbz_nxt       = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_dbz       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_div    <= w_is_div_nxt;
            r_opnd      <= w_opnd_nxt;
            r_acc       <= w_acc_nxt;
            r_lo        <= w_lo_nxt;
            r_result    <= w_result_nxt;
            r_result_hi <= w_result_hi_nxt;
            r_zero      <= w_zero_nxt;
            r_cout      <= w_cout_nxt;
            r_dbz       <= w_dbz_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.result      = r_result;
    assign bus.result_hi   = r_result_hi;
    assign bus.zero        = r_zero;
    assign bus.cout        = r_cout;
    assign bus.div_by_zero = r_dbz;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule
